// File: rtl/add_responder_if.sv
// Operand/result handshake bundle between an operand driver and the adder responder.
interface add_responder_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   y;
    logic [15:0]      done_cnt;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y, done_cnt
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y, done_cnt
    );
endinterface

// File: rtl/add_responder.sv
// Accepts a/b pairs, stores a+b (with carry) in an in-order result FIFO,
// and returns results over a second valid/ready handshake while counting deliveries.
module add_responder #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    add_responder_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0]   OCC_FULL = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   OCC_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } occ_state_t;

    occ_state_t     state;
    occ_state_t     state_next;
    logic [PW:0]    occ;
    logic [PW:0]    occ_next;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [WIDTH:0] mem [DEPTH];
    logic [15:0]    done_q;
    logic           started;
    logic           push;
    logic           pop;

    // started holds in_ready low until the first edge after reset release.
    assign bus.in_ready  = started && (state != FULL);
    assign bus.out_valid = (state != EMPTY);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;
    assign bus.y         = bus.out_valid ? mem[rd_ptr] : '0;
    assign bus.done_cnt  = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            occ     <= '0;
            started <= 1'b0;
        end else begin
            state   <= state_next;
            occ     <= occ_next;
            started <= 1'b1;
        end
    end

    always_comb begin
        occ_next   = occ;
        state_next = state;
        case ({push, pop})
            2'b10:   occ_next = occ + OCC_ONE;
            2'b01:   occ_next = occ - OCC_ONE;
            default: occ_next = occ;
        endcase
        if (occ_next == '0) begin
            state_next = EMPTY;
        end else if (occ_next == OCC_FULL) begin
            state_next = FULL;
        end else begin
            state_next = PARTIAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            done_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                done_q <= done_q + 16'd1;
            end
        end
    end

    // Storage needs no reset: y is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {1'b0, bus.a} + {1'b0, bus.b};
        end
    end
endmodule
